// File: rtl/ysyx_25060173_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU memory arbiter: requester, memory and response sides.
// master = arbiter view, slave = environment view (requesters plus memory).
interface ysyx_25060173_mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_err;

  logic [31:0] rsp_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  ifu_req_valid,
    input  ifu_addr,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_err,
    input  lsu_req_valid,
    input  lsu_addr,
    input  lsu_wen,
    input  lsu_wdata,
    input  lsu_wmask,
    output lsu_req_ready,
    output lsu_rsp_valid,
    output lsu_rsp_err,
    output rsp_rdata,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_addr,
    output mem_wen,
    output mem_wdata,
    output mem_wmask,
    input  mem_rsp_valid,
    input  mem_rdata
  );

  modport slave (
    output ifu_req_valid,
    output ifu_addr,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_err,
    output lsu_req_valid,
    output lsu_addr,
    output lsu_wen,
    output lsu_wdata,
    output lsu_wmask,
    input  lsu_req_ready,
    input  lsu_rsp_valid,
    input  lsu_rsp_err,
    input  rsp_rdata,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_addr,
    input  mem_wen,
    input  mem_wdata,
    input  mem_wmask,
    output mem_rsp_valid,
    output mem_rdata
  );
endinterface

// File: rtl/ysyx_25060173_mem_arbiter.sv
// Single-outstanding IFU/LSU memory arbiter with watchdog timeout.
// MEM_ARB_ROUND_ROBIN_EN: round-robin on ties instead of fixed LSU priority.
module ysyx_25060173_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_25060173_mem_arbiter_if.master bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic        owner_lsu_q, owner_lsu_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ifu_rsp_q, ifu_rsp_d;
  logic        lsu_rsp_q, lsu_rsp_d;
  logic        ifu_err_q, ifu_err_d;
  logic        lsu_err_q, lsu_err_d;
  logic [31:0] cnt_q, cnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_lsu_q, last_lsu_d;
`endif

  logic        idle;
  logic        active;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        ifu_acc;
  logic        lsu_acc;
  logic        acc;
  logic        done;
  logic        expire;

  assign idle    = (state_q == IDLE);
  assign active  = (state_q == REQ) || (state_q == RESP);
  assign ifu_acc = idle && grant_ifu && bus.ifu_req_valid;
  assign lsu_acc = idle && grant_lsu && bus.lsu_req_valid;
  assign acc     = ifu_acc || lsu_acc;
  assign done    = (state_q == RESP) && bus.mem_rsp_valid;

  // cnt_q reads k-1 in the k-th cycle after accept, so the error
  // pulse lands exactly TIMEOUT cycles after the accept cycle.
  assign expire  = (TIMEOUT != 0) && active && !done &&
                   ((cnt_q + 32'd2) >= TIMEOUT);

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (bus.ifu_req_valid && bus.lsu_req_valid) begin
      grant_lsu = !last_lsu_q;
      grant_ifu = last_lsu_q;
    end else begin
      grant_lsu = bus.lsu_req_valid;
      grant_ifu = bus.ifu_req_valid;
    end
`else
    grant_lsu = bus.lsu_req_valid;
    grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc) state_d = REQ;
      end
      REQ: begin
        if (expire) begin
          state_d = IDLE;
        end else if (bus.mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (done || expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ifu_req_ready = ifu_acc;
    bus.lsu_req_ready = lsu_acc;
    bus.mem_req_valid = (state_q == REQ);
    busy              = !idle;
  end

  always_comb begin
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rdata_d     = rdata_q;
    ifu_rsp_d   = 1'b0;
    lsu_rsp_d   = 1'b0;
    ifu_err_d   = 1'b0;
    lsu_err_d   = 1'b0;
    cnt_d       = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_lsu_d  = last_lsu_q;
`endif
    if (acc) begin
      owner_lsu_d = lsu_acc;
      cnt_d       = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_lsu_d  = lsu_acc;
`endif
      if (lsu_acc) begin
        addr_d  = bus.lsu_addr;
        wen_d   = bus.lsu_wen;
        wdata_d = bus.lsu_wdata;
        wmask_d = bus.lsu_wmask;
      end else begin
        addr_d  = bus.ifu_addr;
        wen_d   = 1'b0;
        wdata_d = '0;
        wmask_d = '0;
      end
    end else if (active) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (done) begin
      rdata_d   = bus.mem_rdata;
      ifu_rsp_d = !owner_lsu_q;
      lsu_rsp_d = owner_lsu_q;
    end else if (expire) begin
      rdata_d   = '0;
      ifu_rsp_d = !owner_lsu_q;
      lsu_rsp_d = owner_lsu_q;
      ifu_err_d = !owner_lsu_q;
      lsu_err_d = owner_lsu_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
      ifu_rsp_q   <= 1'b0;
      lsu_rsp_q   <= 1'b0;
      ifu_err_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      ifu_rsp_q   <= ifu_rsp_d;
      lsu_rsp_q   <= lsu_rsp_d;
      ifu_err_q   <= ifu_err_d;
      lsu_err_q   <= lsu_err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu_q <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`endif

  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.ifu_rsp_valid = ifu_rsp_q;
  assign bus.lsu_rsp_valid = lsu_rsp_q;
  assign bus.ifu_rsp_err   = ifu_err_q;
  assign bus.lsu_rsp_err   = lsu_err_q;

endmodule

// File: tb/tb_ysyx_25060173_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (TIMEOUT = 8).
// Honours MEM_ARB_ROUND_ROBIN_EN for the tie-break expectations.
module tb_ysyx_25060173_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  int n_vec = 0;
  int n_err = 0;

  ysyx_25060173_mem_arbiter_if bus ();

  ysyx_25060173_mem_arbiter #(
    .TIMEOUT (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ifu_read(input string tag,
                          input logic [31:0] addr,
                          input logic [31:0] rdata);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = addr;
    #1;
    check({tag, ".ifu_rdy"}, bus.ifu_req_ready, 1);
    check({tag, ".lsu_rdy"}, bus.lsu_req_ready, 0);
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    check({tag, ".mreq"}, bus.mem_req_valid, 1);
    check({tag, ".maddr"}, bus.mem_addr, addr);
    check({tag, ".mwen"}, bus.mem_wen, 0);
    check({tag, ".mwmask"}, bus.mem_wmask, 0);
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = rdata;
    #1;
    check({tag, ".busy"}, busy, 1);
    check({tag, ".mreq_off"}, bus.mem_req_valid, 0);
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    #1;
    check({tag, ".irsp"}, bus.ifu_rsp_valid, 1);
    check({tag, ".ierr"}, bus.ifu_rsp_err, 0);
    check({tag, ".lrsp"}, bus.lsu_rsp_valid, 0);
    check({tag, ".rdata"}, bus.rsp_rdata, rdata);
    cyc();
    check({tag, ".irsp_end"}, bus.ifu_rsp_valid, 0);
  endtask

  logic        exp_l;
  logic [31:0] ia;
  logic [31:0] la;

  initial begin
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wmask     = 4'h0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    check("rst.busy", busy, 0);
    check("rst.mreq", bus.mem_req_valid, 0);
    check("rst.maddr", bus.mem_addr, 0);
    check("rst.mwen", bus.mem_wen, 0);
    check("rst.mwdata", bus.mem_wdata, 0);
    check("rst.mwmask", bus.mem_wmask, 0);
    check("rst.rdata", bus.rsp_rdata, 0);
    check("rst.irsp", bus.ifu_rsp_valid, 0);
    check("rst.lrsp", bus.lsu_rsp_valid, 0);
    check("rst.irdy", bus.ifu_req_ready, 0);
    check("rst.lrdy", bus.lsu_req_ready, 0);

    // Tie-break: both requesters valid for four back-to-back transactions.
    for (int i = 0; i < 4; i++) begin
      exp_l = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_l = (i % 2 == 0);
`endif
      ia = 32'h8000_0100 + 32'(i * 4);
      la = 32'h8000_2000 + 32'(i * 4);
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = ia;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = la;
      bus.lsu_wen       = 1'b0;
      #1;
      check($sformatf("tie%0d.lrdy", i), bus.lsu_req_ready, exp_l);
      check($sformatf("tie%0d.irdy", i), bus.ifu_req_ready, !exp_l);
      cyc();
      if (exp_l) bus.lsu_req_valid = 1'b0;
      else bus.ifu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      #1;
      check($sformatf("tie%0d.blocked", i),
            bus.ifu_req_ready | bus.lsu_req_ready, 0);
      check($sformatf("tie%0d.maddr", i), bus.mem_addr, exp_l ? la : ia);
      cyc();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 32'h0000_00a0 + 32'(i);
      cyc();
      bus.mem_rsp_valid = 1'b0;
      #1;
      check($sformatf("tie%0d.lrsp", i), bus.lsu_rsp_valid, exp_l);
      check($sformatf("tie%0d.irsp", i), bus.ifu_rsp_valid, !exp_l);
      check($sformatf("tie%0d.rdata", i), bus.rsp_rdata,
            32'h0000_00a0 + 32'(i));
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    cyc();
    check("tie.idle", busy, 0);

    ifu_read("ifu1", 32'h8000_0000, 32'h0010_0093);

    // LSU write with memory stalling the request for four cycles.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hdead_beef;
    bus.lsu_wmask     = 4'hf;
    #1;
    check("wr.lrdy", bus.lsu_req_ready, 1);
    cyc();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wmask     = 4'h0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_req_ready = (k == 4);
      #1;
      check($sformatf("wr.req%0d", k), bus.mem_req_valid, 1);
      check($sformatf("wr.addr%0d", k), bus.mem_addr, 32'h8000_1000);
      check($sformatf("wr.wen%0d", k), bus.mem_wen, 1);
      check($sformatf("wr.wdata%0d", k), bus.mem_wdata, 32'hdead_beef);
      check($sformatf("wr.wmask%0d", k), bus.mem_wmask, 4'hf);
      cyc();
    end
    bus.mem_req_ready = 1'b0;
    check("wr.resp_wait", bus.lsu_rsp_valid, 0);
    cyc();
    check("wr.resp_wait2", bus.lsu_rsp_valid, 0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h0000_1234;
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    #1;
    check("wr.lrsp", bus.lsu_rsp_valid, 1);
    check("wr.lerr", bus.lsu_rsp_err, 0);
    check("wr.irsp", bus.ifu_rsp_valid, 0);
    check("wr.rdata", bus.rsp_rdata, 32'h0000_1234);
    cyc();
    check("wr.lrsp_end", bus.lsu_rsp_valid, 0);

    // Timeout in RESP: memory accepts but never answers.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    #1;
    check("to1.irdy", bus.ifu_req_ready, 1);
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    repeat (5) cyc();
    check("to1.t7_irsp", bus.ifu_rsp_valid, 0);
    check("to1.t7_busy", busy, 1);
    cyc();
    check("to1.irsp", bus.ifu_rsp_valid, 1);
    check("to1.ierr", bus.ifu_rsp_err, 1);
    check("to1.lrsp", bus.lsu_rsp_valid, 0);
    check("to1.rdata", bus.rsp_rdata, 0);
    check("to1.busy", busy, 0);
    cyc();
    check("to1.ierr_end", bus.ifu_rsp_err, 0);

    // Timeout in REQ: memory never accepts, so the request must drop.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    bus.lsu_wen       = 1'b0;
    #1;
    check("to2.lrdy", bus.lsu_req_ready, 1);
    cyc();
    bus.lsu_req_valid = 1'b0;
    repeat (6) cyc();
    check("to2.t7_mreq", bus.mem_req_valid, 1);
    cyc();
    check("to2.lrsp", bus.lsu_rsp_valid, 1);
    check("to2.lerr", bus.lsu_rsp_err, 1);
    check("to2.mreq", bus.mem_req_valid, 0);
    cyc();

    ifu_read("ifu2", 32'h8000_0008, 32'h0020_0113);

    // Reset while in RESP, with a memory response arriving the same cycle.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0080;
    #1;
    cyc();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    check("rr.in_resp", busy, 1);
    rst               = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h0000_0055;
    cyc();
    rst               = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    #1;
    check("rr.busy", busy, 0);
    check("rr.mreq", bus.mem_req_valid, 0);
    check("rr.maddr", bus.mem_addr, 0);
    check("rr.rdata", bus.rsp_rdata, 0);
    check("rr.irsp", bus.ifu_rsp_valid, 0);
    check("rr.lrsp", bus.lsu_rsp_valid, 0);
    cyc();
    check("rr.irsp2", bus.ifu_rsp_valid, 0);

    ifu_read("ifu3", 32'h8000_0004, 32'h0030_0193);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
